// File: rtl/compress_ctrl_pkg.sv
// Shared constants and FSM state type for the compression job sequencer.
package compress_ctrl_pkg;

  localparam logic [3:0] OFF_CTRL    = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_IN_LEN  = 4'h8;
  localparam logic [3:0] OFF_OUT_LEN = 4'hC;

  localparam logic [1:0] IDX_CTRL    = OFF_CTRL[3:2];
  localparam logic [1:0] IDX_STATUS  = OFF_STATUS[3:2];
  localparam logic [1:0] IDX_IN_LEN  = OFF_IN_LEN[3:2];
  localparam logic [1:0] IDX_OUT_LEN = OFF_OUT_LEN[3:2];

  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_ABORT   = 2;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/compress_axil_regs.sv
// AXI4-Lite slave and register storage for the compression sequencer.
// Emits single-cycle START/ABORT pulses and W1C clear strobes to the controller.
module compress_axil_regs
  import compress_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [31:0]       rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  input  logic              busy_i,
  input  logic              done_i,
  input  logic              timeout_i,
  input  logic [LEN_W-1:0]  out_len_i,
  output logic              start_o,
  output logic              abort_o,
  output logic              done_clr_o,
  output logic              timeout_clr_o,
  output logic              irq_en_o,
  output logic [LEN_W-1:0]  in_len_o
);

  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d, irq_en_q, irq_en_d;
  logic [31:0] rdata_q, rdata_d, in_len_q, in_len_d, rd_mux;
  logic        wr_hs, rd_hs, wr_ctrl, wr_status, wr_len;
  logic [1:0]  wr_idx, rd_idx;
  logic        unused_addr;

  assign wr_idx      = awaddr_i[3:2];
  assign rd_idx      = araddr_i[3:2];
  assign unused_addr = ^{awaddr_i, araddr_i};

  // Address and data are accepted together, only while no response is pending.
  assign wr_hs     = awvalid_i && wvalid_i && !bvalid_q;
  assign rd_hs     = arvalid_i && !rvalid_q;
  assign wr_ctrl   = wr_hs && (wr_idx == IDX_CTRL) && wstrb_i[0];
  assign wr_status = wr_hs && (wr_idx == IDX_STATUS) && wstrb_i[0];
  assign wr_len    = wr_hs && (wr_idx == IDX_IN_LEN);

  assign awready_o     = wr_hs;
  assign wready_o      = wr_hs;
  assign arready_o     = !rvalid_q;
  assign bvalid_o      = bvalid_q;
  assign rvalid_o      = rvalid_q;
  assign rdata_o       = rdata_q;
  assign bresp_o       = 2'b00;
  assign rresp_o       = 2'b00;
  assign start_o       = wr_ctrl && wdata_i[CTRL_START];
  assign abort_o       = wr_ctrl && wdata_i[CTRL_ABORT];
  assign done_clr_o    = wr_status && wdata_i[STAT_DONE];
  assign timeout_clr_o = wr_status && wdata_i[STAT_TIMEOUT];
  assign irq_en_o      = irq_en_q;
  assign in_len_o      = in_len_q[LEN_W-1:0];

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      IDX_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en_q;
      IDX_STATUS: begin
        rd_mux[STAT_BUSY]    = busy_i;
        rd_mux[STAT_DONE]    = done_i;
        rd_mux[STAT_TIMEOUT] = timeout_i;
      end
      IDX_IN_LEN: rd_mux = in_len_q;
      default:    rd_mux[LEN_W-1:0] = out_len_i;
    endcase
  end

  always_comb begin
    bvalid_d = bvalid_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    irq_en_d = irq_en_q;
    in_len_d = in_len_q;
    if (wr_hs)         bvalid_d = 1'b1;
    else if (bready_i) bvalid_d = 1'b0;
    if (rd_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rready_i) begin
      rvalid_d = 1'b0;
    end
    if (wr_ctrl) irq_en_d = wdata_i[CTRL_IRQ_EN];
    if (wr_len) begin
      for (int b = 0; b < 4; b++)
        if (wstrb_i[b]) in_len_d[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      irq_en_q <= 1'b0;
      in_len_q <= '0;
    end else begin
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      irq_en_q <= irq_en_d;
      in_len_q <= in_len_d;
    end
  end

endmodule

// File: rtl/compress_core_sequencer.sv
// Job sequencer for the fastqz compression core: start handshake, watchdog,
// completion capture and level interrupt behind an AXI4-Lite register bank.
module compress_core_sequencer
  import compress_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int LEN_W          = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [DATA_W-1:0] S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [DATA_W-1:0] S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic              core_start,
  input  logic              core_ready,
  output logic [LEN_W-1:0]  core_len,
  input  logic              core_done,
  input  logic [LEN_W-1:0]  core_out_len,
  output logic              core_abort,
  output logic              irq
);

  localparam bit          WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   core_len_q, core_len_d, out_len_q, out_len_d, in_len;
  logic [31:0]        wdog_q, wdog_d;
  logic               done_q, done_d, timeout_q, timeout_d, abort_q, abort_d, irq_q;
  logic               start_req, abort_req, done_clr, timeout_clr, irq_en;

  compress_axil_regs #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_regs (
    .clk_i(ACLK), .rst_ni(ARESETN),
    .awaddr_i(S_AXI_AWADDR), .awvalid_i(S_AXI_AWVALID), .awready_o(S_AXI_AWREADY),
    .wdata_i(S_AXI_WDATA), .wstrb_i(S_AXI_WSTRB), .wvalid_i(S_AXI_WVALID),
    .wready_o(S_AXI_WREADY), .bresp_o(S_AXI_BRESP), .bvalid_o(S_AXI_BVALID),
    .bready_i(S_AXI_BREADY), .araddr_i(S_AXI_ARADDR), .arvalid_i(S_AXI_ARVALID),
    .arready_o(S_AXI_ARREADY), .rdata_o(S_AXI_RDATA), .rresp_o(S_AXI_RRESP),
    .rvalid_o(S_AXI_RVALID), .rready_i(S_AXI_RREADY),
    .busy_i(state_q != ST_IDLE), .done_i(done_q), .timeout_i(timeout_q),
    .out_len_i(out_len_q), .start_o(start_req), .abort_o(abort_req),
    .done_clr_o(done_clr), .timeout_clr_o(timeout_clr), .irq_en_o(irq_en),
    .in_len_o(in_len)
  );

  assign core_start = (state_q == ST_ISSUE);
  assign core_len   = core_len_q;
  assign core_abort = abort_q;
  assign irq        = irq_q;

  // Completion outranks both the watchdog and a software abort; a status set
  // is applied after the W1C clear so that the set wins.
  always_comb begin
    state_d    = state_q;
    core_len_d = core_len_q;
    out_len_d  = out_len_q;
    wdog_d     = wdog_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    abort_d    = 1'b0;
    if (done_clr)    done_d    = 1'b0;
    if (timeout_clr) timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d    = ST_ISSUE;
          core_len_d = in_len;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      ST_ISSUE: begin
        wdog_d = '0;
        if (abort_req) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (core_ready) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        wdog_d = wdog_q + 32'd1;
        if (core_done) begin
          out_len_d = core_out_len;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
          abort_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (abort_req) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_IDLE;
      core_len_q <= '0;
      out_len_q  <= '0;
      wdog_q     <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      abort_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_len_q <= core_len_d;
      out_len_q  <= out_len_d;
      wdog_q     <= wdog_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      abort_q    <= abort_d;
      irq_q      <= irq_en && (done_d || timeout_d);
    end
  end

endmodule
